// File: rtl/reg_bank_stack.sv
// reg_bank_stack: NREGS-entry register bank with four-source load.
// Register 0 (accumulator) has a DEPTH-entry LIFO save/restore stack.
module reg_bank_stack #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int DEPTH = 8,
  localparam int AW  = (NREGS > 2) ? $clog2(NREGS) : 1,
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        iInbox,
  input  logic [WIDTH-1:0]        iMem,
  input  logic [WIDTH-1:0]        iData,
  input  logic [WIDTH-1:0]        iAlu,
  input  logic [1:0]              muxR,
  input  logic                    wR,
  input  logic [AW-1:0]           wAddr,
  input  logic [AW-1:0]           rAddr,
  input  logic                    push,
  input  logic                    pop,
  output logic signed [WIDTH-1:0] R,
  output logic signed [WIDTH-1:0] rData,
  output logic [SPW-1:0]          sp,
  output logic                    empty,
  output logic                    full,
  output logic                    err
);

  localparam int SAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] NR = (AW + 1)'(NREGS);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } st_e;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  st_e              st_q, st_d;

  logic             op_push, op_pop, op_swap;
  logic             push_ok, pop_ok, swap_ok;
  logic             stk_we;
  logic [SAW-1:0]   top_idx, stk_waddr;
  logic [WIDTH-1:0] src;
  logic             wr_ok;

  // Load source select and stack operation decode
  always_comb begin
    src = iInbox;
    unique case (muxR)
      2'd0: src = iInbox;
      2'd1: src = iMem;
      2'd2: src = iData;
      2'd3: src = iAlu;
    endcase
    op_push   = push & ~pop;
    op_pop    = pop & ~push;
    op_swap   = push & pop;
    push_ok   = op_push & ~empty;
    push_ok   = op_push & ~full;
    pop_ok    = op_pop & ~empty;
    swap_ok   = op_swap & ~empty;
    top_idx   = SAW'(sp_q - SPW'(1));
    stk_we    = ~rst & (push_ok | swap_ok);
    stk_waddr = push_ok ? SAW'(sp_q) : top_idx;
    wr_ok     = wR & ({1'b0, wAddr} < NR);
  end

  // Next register, pointer and error state
  always_comb begin
    regs_d = regs_q;
    sp_d   = sp_q;
    err_d  = err_q;
    if (wr_ok) regs_d[wAddr] = src;
    if (pop_ok | swap_ok) regs_d[0] = stack_q[top_idx];
    if (push_ok) sp_d = sp_q + SPW'(1);
    if (pop_ok) sp_d = sp_q - SPW'(1);
    if ((op_push & full) | ((op_pop | op_swap) & empty))
      err_d = 1'b1;
  end

  // Register bank, pointer and sticky error flops
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      sp_q   <= sp_d;
      err_q  <= err_d;
    end
  end

  // Stack storage, not reset
  always_ff @(posedge clk) begin
    if (stk_we) stack_q[stk_waddr] <= regs_q[0];
  end

  // Occupancy FSM state register
  always_ff @(posedge clk) begin
    if (rst) st_q <= S_EMPTY;
    else     st_q <= st_d;
  end

  // Occupancy FSM next state, tracks sp
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_EMPTY: begin
        if (push_ok)
          st_d = (DEPTH == 1) ? S_FULL : S_PARTIAL;
      end
      S_PARTIAL: begin
        if (push_ok && sp_q == SPW'(DEPTH - 1))
          st_d = S_FULL;
        else if (pop_ok && sp_q == SPW'(1))
          st_d = S_EMPTY;
      end
      S_FULL: begin
        if (pop_ok)
          st_d = (DEPTH == 1) ? S_EMPTY : S_PARTIAL;
      end
      default: st_d = S_EMPTY;
    endcase
  end

  // Occupancy FSM outputs
  always_comb begin
    empty = 1'b0;
    full  = 1'b0;
    unique case (st_q)
      S_EMPTY:   empty = 1'b1;
      S_PARTIAL: ;
      S_FULL:    full = 1'b1;
      default:   empty = 1'b1;
    endcase
  end

  // Read ports and status
  always_comb begin
    R     = regs_q[0];
    rData = ({1'b0, rAddr} < NR) ? regs_q[rAddr] : '0;
    sp    = sp_q;
    err   = err_q;
  end

`ifndef SYNTHESIS
  logic seen_rst_q;

  // Remember that a reset has been applied
  always @(posedge clk) begin
    if (rst) seen_rst_q <= 1'b1;
  end

  // Trace accumulator changes
  always @(R) begin
    $display("reg_bank_stack: R = %0h", R);
  end

  // State must be fully known once reset has been seen
  always @(posedge clk) begin
    if (seen_rst_q === 1'b1 && !rst)
      assert (!$isunknown({regs_q[0], sp_q, err_q}))
      else $error("reg_bank_stack: unknown bits in R/sp/err");
  end
`endif

endmodule

// File: doc/reg_bank_stack.md
# reg_bank_stack

Parametrised successor to the single accumulator register of the HRM CPU datapath. It holds a bank of `NREGS` registers, each `WIDTH` bits wide, loaded through the same four-source select. Register 0 is the accumulator, and a LIFO save/restore stack of depth `DEPTH` is attached to it, so microcode can spill and reload the accumulator (e.g. around subroutine calls). It sits between the inbox/memory/ALU/immediate sources and the ALU/outbox consumers.

## Interface
- `WIDTH`, 8, data width of every register and stack entry.
- `NREGS`, 4, number of registers; must be at least 2. Register 0 is the accumulator.
- `DEPTH`, 8, number of stack entries; must be at least 1.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `iInbox`  in  WIDTH  source 0.
- `iMem`  in  WIDTH  source 1.
- `iData`  in  WIDTH  source 2.
- `iAlu`  in  WIDTH  source 3.
- `muxR`  in  2  source select: 00 inbox, 01 mem, 10 data, 11 alu.
- `wR`  in  1  write enable for `regs[wAddr]`.
- `wAddr`  in  max(1,$clog2(NREGS))  write address.
- `rAddr`  in  max(1,$clog2(NREGS))  read address.
- `push`  in  1  save `regs[0]` onto the stack.
- `pop`  in  1  restore `regs[0]` from the top of the stack.
- `R`  out  WIDTH signed  `regs[0]`, continuously driven.
- `rData`  out  WIDTH signed  `regs[rAddr]`, combinational.
- `sp`  out  $clog2(DEPTH+1)  number of valid stack entries.
- `empty`  out  1  `sp == 0`.
- `full`  out  1  `sp == DEPTH`.
- `err`  out  1  sticky overflow/underflow flag.

## Operation
- Reset (`rst`=1 at an edge) has priority over every other input.
  - Clears all registers to 0 and sets `sp` to 0.
  - Outputs after reset: `R`=0, `rData`=0, `sp`=0, `empty`=1, `full`=0, `err`=0.
  - Stack RAM contents are not reset; they are unobservable until pushed.
- Write: when `wR`=1, `regs[wAddr]` takes the source selected by `muxR`. `wAddr >= NREGS` is ignored (no write, no error).
- Push (`push`=1, `pop`=0):
  - Not full: `stack[sp]` takes the pre-edge `regs[0]`, then `sp` increments.
  - Full: no change to stack or `sp`; `err` is set.
- Pop (`pop`=1, `push`=0):
  - Not empty: `regs[0]` takes `stack[sp-1]`, then `sp` decrements.
  - Empty: no change to stack, `sp` or `regs[0]`; `err` is set.
- Swap (`push`=1, `pop`=1):
  - Not empty: `stack[sp-1]` takes the old `regs[0]` and `regs[0]` takes the old `stack[sp-1]`; `sp` is unchanged.
  - Empty: no change; `err` is set.
- Collisions on register 0:
  - A successful pop or swap overrides a same-cycle `wR` to address 0, and that write is dropped.
  - A failed pop or swap does not block `wR`.
  - `wR` to any other address always proceeds alongside a stack operation.
  - A push plus `wR` to address 0 saves the old value and writes the new one.
- `err` stays at 1 until reset.
- Stack pointer control is a 3-state FSM derived from `sp`: EMPTY, PARTIAL, FULL.
  - EMPTY to PARTIAL on push (or to FULL if `DEPTH`=1).
  - PARTIAL to FULL on a push at `sp==DEPTH-1`.
  - PARTIAL to EMPTY on a pop at `sp==1`.
  - FULL to PARTIAL on pop (or to EMPTY if `DEPTH`=1).
  - Swap never changes state.

## Timing
- Every update (register write, push, pop, `sp`, `err`) is visible the cycle after the edge at which it is sampled. Write latency is 1.
- `rData` and `R` are combinational from the registers: zero-cycle read, no read-during-write bypass. Reading the address being written returns the old value until the edge.
- `empty` and `full` are decoded from registered `sp`, so they are valid in the same cycle `sp` changes.
- Back-to-back push/pop on consecutive cycles is fully supported, with no bubbles.
- Reset mid-sequence discards the stack: `sp`=0 on the next cycle regardless of the operation in flight.
- Simulation only: prints `R` on every change; it asserts that `R`, `sp` and `err` have no X/Z bits after the first reset.

## Test plan
- Reset, then `wR`=1, `muxR`=11, `iAlu`=8'h5A, `wAddr`=2 → next cycle `rAddr`=2 gives `rData`=8'h5A; `R`=0.
- Load `R`=8'h11 and push, then load `R`=8'h22 and push, then load `R`=8'h33 and pop → `R`=8'h22, `sp`=1. Pop again → `R`=8'h11, `sp`=0, `empty`=1, `err`=0.
- `DEPTH`=8: nine pushes → `full`=1 after the 8th, `sp` stays 8, `err`=1 after the 9th. Then pop → `sp`=7 and `err` stays 1.
- Pop on empty with `wR` to address 0 and `iInbox`=8'h7F → `R`=8'h7F, `err`=1, `sp`=0.
- Swap test: with `R`=8'hAA and stack top 8'hBB, assert push and pop together → `R`=8'hBB, top becomes 8'hAA, `sp` unchanged. A following pop → `R`=8'hAA.
- Push with `wR`=1 to address 0 (`iData`=8'h44) while `R`=8'h10 → `R`=8'h44. Then pop → `R`=8'h10. Finally, assert `rst` during a pop → all outputs return to their reset values.
